// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle datapath. Walks each instruction
// through fetch/decode/execute/memory/writeback, drives every datapath
// strobe, and folds the branch condition into the PC write enable because
// the PC register has no conditional-write input of its own.
module multicycle_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [5:0]       i_opcode,
  input  logic             i_zero,
  output logic             o_pcwrite,
  output logic [1:0]       o_pc_source,
  output logic             o_iord,
  output logic             o_memread,
  output logic             o_memwrite,
  output logic             o_irwrite,
  output logic             o_memtoreg,
  output logic             o_regdst,
  output logic             o_regwrite,
  output logic             o_alusrca,
  output logic [1:0]       o_alusrcb,
  output logic [1:0]       o_aluop,
  output logic             o_illegal_op,
  output logic             o_instr_retired,
  output logic [CNT_W-1:0] o_retired_count,
  output logic [3:0]       o_state_out
);

  localparam logic [3:0] S_RESET  = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC_R = 4'd7;
  localparam logic [3:0] S_RWB    = 4'd8;
  localparam logic [3:0] S_EXEC_I = 4'd9;
  localparam logic [3:0] S_IWB    = 4'd10;
  localparam logic [3:0] S_BRANCH = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0]       r_state;
  logic [3:0]       w_state_next;
  logic [CNT_W-1:0] r_retired_count;

  // State register; reset pulls the FSM to RESET without waiting for a clock
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; opcode is only consulted in DECODE and MEMADR
  always_comb begin
    w_state_next = S_FETCH;
    case (r_state)
      S_RESET:  w_state_next = S_FETCH;
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          OP_RTYPE:       w_state_next = S_EXEC_R;
          OP_LW, OP_SW:   w_state_next = S_MEMADR;
          OP_BEQ, OP_BNE: w_state_next = S_BRANCH;
          OP_J:           w_state_next = S_JUMP;
          OP_ADDI:        w_state_next = S_EXEC_I;
          default:        w_state_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_state_next = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_state_next = S_MEMWB;
      S_EXEC_R: w_state_next = S_RWB;
      S_EXEC_I: w_state_next = S_IWB;
      default:  w_state_next = S_FETCH;
    endcase
  end

  // Output decode: Moore on the state register, except the branch PC enable
  always_comb begin
    o_pcwrite       = 1'b0;
    o_pc_source     = 2'b00;
    o_iord          = 1'b0;
    o_memread       = 1'b0;
    o_memwrite      = 1'b0;
    o_irwrite       = 1'b0;
    o_memtoreg      = 1'b0;
    o_regdst        = 1'b0;
    o_regwrite      = 1'b0;
    o_alusrca       = 1'b0;
    o_alusrcb       = 2'b00;
    o_aluop         = 2'b00;
    o_illegal_op    = 1'b0;
    o_instr_retired = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_memread = 1'b1;
        o_irwrite = 1'b1;
        o_pcwrite = 1'b1;
      end
      S_DECODE: begin
        // ALUOut <= PC + offset so BRANCH finds its target ready
        o_alusrcb = 2'b10;
        case (i_opcode)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI: ;
          default: begin
            o_illegal_op    = 1'b1;
            o_instr_retired = 1'b1;
          end
        endcase
      end
      S_MEMADR, S_EXEC_I: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
      end
      S_MEMRD: begin
        o_memread = 1'b1;
        o_iord    = 1'b1;
      end
      S_MEMWB: begin
        o_regwrite      = 1'b1;
        o_memtoreg      = 1'b1;
        o_instr_retired = 1'b1;
      end
      S_MEMWR: begin
        o_memwrite      = 1'b1;
        o_iord          = 1'b1;
        o_instr_retired = 1'b1;
      end
      S_EXEC_R: begin
        o_alusrca = 1'b1;
        o_aluop   = 2'b10;
      end
      S_RWB: begin
        o_regwrite      = 1'b1;
        o_regdst        = 1'b1;
        o_instr_retired = 1'b1;
      end
      S_IWB: begin
        o_regwrite      = 1'b1;
        o_instr_retired = 1'b1;
      end
      S_BRANCH: begin
        o_alusrca       = 1'b1;
        o_aluop         = 2'b01;
        o_pc_source     = 2'b01;
        o_instr_retired = 1'b1;
        // The PC cannot condition its own load, so the taken test lives here
        o_pcwrite       = (i_opcode == OP_BNE) ? ~i_zero : i_zero;
      end
      S_JUMP: begin
        o_pcwrite       = 1'b1;
        o_pc_source     = 2'b10;
        o_instr_retired = 1'b1;
      end
      default: ;
    endcase
  end

  // Retired-instruction counter, free-running with natural wrap
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_retired_count <= '0;
    end else if (o_instr_retired) begin
      r_retired_count <= r_retired_count + CNT_W'(1);
    end
  end

  assign o_retired_count = r_retired_count;
  assign o_state_out     = r_state;

endmodule
